// File: rtl/axis2port_framer_if.sv
// AXI-stream slave bundle feeding the framer: payload word, valid, last, ready.
interface axis2port_framer_if;
  logic [63:0] TDATA;
  logic        TVALID;
  logic        TLAST;
  logic        TREADY;

  modport master (output TDATA, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/axis2port_framer.sv
// Buffers TLAST-delimited AXI-stream frames whole and re-emits each one as an
// OpenFC port packet: ROUTE_WORDS header words, one length word, then payload.
module axis2port_framer #(
  parameter int ROUTE_WORDS = 1,
  parameter int DEPTH_LOG2  = 9,
  parameter int FRAMES_LOG2 = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  axis2port_framer_if.slave        s_axis,
  input  logic [167:0]             ROUTE,
  output logic [63:0]              Q,
  output logic                     Q_VALID,
  input  logic                     Q_BP,
  output logic                     OVERSIZE
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int FRAMES = 1 << FRAMES_LOG2;
  localparam logic [DEPTH_LOG2:0]  P_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [FRAMES_LOG2:0] F_ONE    = (FRAMES_LOG2 + 1)'(1);
  localparam logic [1:0]           LAST_HDR = (ROUTE_WORDS > 0) ? 2'(ROUTE_WORDS - 1) : 2'd0;

  typedef enum logic [1:0] {IDLE, HDR, LEN, PAY} state_t;

  // Payload buffer and length FIFO; pointers carry one extra wrap bit.
  logic [63:0]            pay_mem [DEPTH];
  logic [DEPTH_LOG2:0]    len_mem [FRAMES];
  logic [DEPTH_LOG2:0]    pay_wr_q, pay_rd_q, pay_rd_d;
  logic [FRAMES_LOG2:0]   len_wr_q, len_rd_q;
  logic [63:0]            pf_q;

  // Input-side frame tracking.
  logic [31:0]            fcnt_q;
  logic                   oversize_q;
  logic                   pay_full, len_full, len_empty;
  logic                   accept, at_limit, end_frame;

  // Output FSM state.
  state_t                 state_q, state_d;
  logic [1:0]             hdr_idx_q, hdr_idx_d;
  logic [DEPTH_LOG2:0]    plen_q, plen_d;
  logic [2:0][55:0]       route_q, route_d;
  logic [63:0]            q_q, q_d;
  logic                   q_valid_q, q_valid_d;
  logic                   pay_pop, len_pop;

  assign pay_full  = (pay_wr_q[DEPTH_LOG2] != pay_rd_q[DEPTH_LOG2]) &&
                     (pay_wr_q[DEPTH_LOG2-1:0] == pay_rd_q[DEPTH_LOG2-1:0]);
  assign len_full  = (len_wr_q[FRAMES_LOG2] != len_rd_q[FRAMES_LOG2]) &&
                     (len_wr_q[FRAMES_LOG2-1:0] == len_rd_q[FRAMES_LOG2-1:0]);
  assign len_empty = (len_wr_q == len_rd_q);

  assign s_axis.TREADY = ~RST & ~pay_full & ~len_full;
  assign accept        = s_axis.TVALID & s_axis.TREADY;
  assign at_limit      = (fcnt_q + 32'd1) == 32'(DEPTH);
  assign end_frame     = s_axis.TLAST | at_limit;

  // Write side: advance write pointers, count words, close frames.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pay_wr_q   <= '0;
      len_wr_q   <= '0;
      fcnt_q     <= '0;
      oversize_q <= 1'b0;
    end else if (accept) begin
      pay_wr_q <= pay_wr_q + P_ONE;
      if (end_frame) begin
        len_wr_q <= len_wr_q + F_ONE;
        fcnt_q   <= '0;
        if (!s_axis.TLAST) oversize_q <= 1'b1;
      end else begin
        fcnt_q <= fcnt_q + 32'd1;
      end
    end
  end

  // Storage arrays: payload words and completed frame lengths.
  // NOTE: the memories are not reset; pointers alone define which entries are live.
  always_ff @(posedge CLK) begin
    if (accept) pay_mem[pay_wr_q[DEPTH_LOG2-1:0]] <= s_axis.TDATA;
    if (accept && end_frame)
      len_mem[len_wr_q[FRAMES_LOG2-1:0]] <= fcnt_q[DEPTH_LOG2:0] + P_ONE;
  end

  assign pay_rd_d = pay_rd_q + (pay_pop ? P_ONE : '0);

  // Prefetch: always holds the word at the read pointer. A same-cycle write to
  // that slot returns stale data for one cycle only, and PAY is never entered
  // that soon after a frame's last word lands.
  always_ff @(posedge CLK) begin
    pf_q <= pay_mem[pay_rd_d[DEPTH_LOG2-1:0]];
  end

  // Read-side pointers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pay_rd_q <= '0;
      len_rd_q <= '0;
    end else begin
      pay_rd_q <= pay_rd_d;
      if (len_pop) len_rd_q <= len_rd_q + F_ONE;
    end
  end

  // Output FSM and registered Q/Q_VALID.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      hdr_idx_q <= '0;
      plen_q    <= '0;
      route_q   <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      plen_q    <= plen_d;
      route_q   <= route_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  // Next-state and emitted word; nothing advances while Q_BP is high.
  // NOTE: every output gets a default first, so no path through the block infers a latch.
  always_comb begin
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    plen_d    = plen_q;
    route_d   = route_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    len_pop   = 1'b0;
    pay_pop   = 1'b0;
    if (!Q_BP) begin
      case (state_q)
        IDLE: begin
          if (!len_empty) begin
            len_pop   = 1'b1;
            plen_d    = len_mem[len_rd_q[FRAMES_LOG2-1:0]];
            route_d   = ROUTE;
            hdr_idx_d = '0;
            state_d   = (ROUTE_WORDS == 0) ? LEN : HDR;
          end
        end
        HDR: begin
          q_d       = {8'h01, route_q[hdr_idx_q]};
          q_valid_d = 1'b1;
          if (hdr_idx_q == LAST_HDR) state_d = LEN;
          else hdr_idx_d = hdr_idx_q + 2'd1;
        end
        LEN: begin
          q_d       = {32'h0, 32'(plen_q)};
          q_valid_d = 1'b1;
          state_d   = PAY;
        end
        PAY: begin
          q_d       = pf_q;
          q_valid_d = 1'b1;
          pay_pop   = 1'b1;
          plen_d    = plen_q - P_ONE;
          if (plen_q == P_ONE) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign Q        = q_q;
  assign Q_VALID  = q_valid_q;
  assign OVERSIZE = oversize_q;

endmodule

// File: tb/tb_axis2port_framer.sv
// Self-checking bench for axis2port_framer: a frame-level scoreboard predicts
// every Q word from the accepted input stream, plus directed literal checks.
module tb_axis2port_framer;

  localparam int RW    = 1;
  localparam int DL    = 4;
  localparam int FL    = 4;
  localparam int DEPTH = 1 << DL;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [167:0] ROUTE;
  logic [63:0]  Q;
  logic         Q_VALID;
  logic         Q_BP = 1'b0;
  logic         OVERSIZE;

  axis2port_framer_if s_axis ();

  axis2port_framer #(.ROUTE_WORDS(RW), .DEPTH_LOG2(DL), .FRAMES_LOG2(FL)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .s_axis   (s_axis),
    .ROUTE    (ROUTE),
    .Q        (Q),
    .Q_VALID  (Q_VALID),
    .Q_BP     (Q_BP),
    .OVERSIZE (OVERSIZE)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [63:0] exp_q [$];
  logic [63:0] cur_frame [$];
  logic [63:0] obs_data [$];
  int          obs_cyc [$];
  logic        exp_oversize = 1'b0;
  logic        bp_prev = 1'b0;
  int          last_hs = 0;
  logic        bp_rand = 1'b0;
  logic        bp_force = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Backpressure source: fixed level or a fair coin each cycle.
  always @(posedge CLK) begin
    #1;
    Q_BP = bp_rand ? 1'($urandom_range(0, 1)) : bp_force;
  end

  // Scoreboard: compare what the last edge produced, then fold in what the next edge accepts.
  always @(negedge CLK) begin
    if (cyc > 0) begin
      if (Q_VALID) begin
        obs_data.push_back(Q);
        obs_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_word", 64'(Q_VALID), 64'd0);
        else check("q_word", Q, exp_q.pop_front());
      end
      if (bp_prev) check("valid_after_bp", 64'(Q_VALID), 64'd0);
      check("oversize", 64'(OVERSIZE), 64'(exp_oversize));
      bp_prev = Q_BP;
      if (RST) begin
        exp_q.delete();
        cur_frame.delete();
        exp_oversize = 1'b0;
      end else if (s_axis.TVALID && s_axis.TREADY) begin
        cur_frame.push_back(s_axis.TDATA);
        if (s_axis.TLAST || cur_frame.size() == DEPTH) begin
          if (!s_axis.TLAST) exp_oversize = 1'b1;
          else last_hs = cyc + 1;
          for (int i = 0; i < RW; i++) exp_q.push_back({8'h01, ROUTE[56*i +: 56]});
          exp_q.push_back(64'(cur_frame.size()));
          foreach (cur_frame[i]) exp_q.push_back(cur_frame[i]);
          cur_frame.delete();
        end
      end
    end
  end

  task automatic send_word(input logic [63:0] data, input logic last, input int gap_max);
    int gap;
    logic took;
    gap  = int'($urandom_range(gap_max, 0));
    took = 1'b0;
    s_axis.TVALID = 1'b0;
    repeat (gap) begin @(posedge CLK); #1; end
    s_axis.TDATA  = data;
    s_axis.TLAST  = last;
    s_axis.TVALID = 1'b1;
    for (int w = 0; w < 400 && !took; w++) begin
      @(negedge CLK);
      if (s_axis.TREADY) took = 1'b1;
      @(posedge CLK); #1;
    end
    s_axis.TVALID = 1'b0;
    s_axis.TLAST  = 1'b0;
    if (!took) check("send_timeout", 64'(took), 64'd1);
  endtask

  task automatic send_frame(input int len, input int gap_max);
    for (int i = 0; i < len; i++)
      send_word({$urandom(), $urandom()}, 1'(i == len - 1), gap_max);
  endtask

  task automatic drain(input int budget);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < budget) begin
      @(negedge CLK);
      w++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic rand_route();
    for (int i = 0; i < 168; i++) ROUTE[i] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] lit [5];
    s_axis.TDATA  = '0;
    s_axis.TVALID = 1'b0;
    s_axis.TLAST  = 1'b0;
    ROUTE = 168'h5;

    // Reset state.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_q_valid", 64'(Q_VALID), 64'd0);
    check("rst_q", Q, 64'd0);
    check("rst_tready", 64'(s_axis.TREADY), 64'd0);
    check("rst_oversize", 64'(OVERSIZE), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("tready_after_rst", 64'(s_axis.TREADY), 64'd1);
    @(posedge CLK); #1;

    // Directed 3-word frame; ROUTE changes right after the header is latched.
    obs_data.delete(); obs_cyc.delete();
    lit[0] = 64'h0100_0000_0000_0005;
    lit[1] = 64'h3;
    lit[2] = 64'hAAAA_0000_0000_0001;
    lit[3] = 64'hBBBB_0000_0000_0002;
    lit[4] = 64'hCCCC_0000_0000_0003;
    send_word(lit[2], 1'b0, 0);
    send_word(lit[3], 1'b0, 0);
    send_word(lit[4], 1'b1, 0);
    @(posedge CLK); #1;
    ROUTE = '1;
    drain(200);
    check("t1_count", 64'(obs_data.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < obs_data.size()) begin
        check("t1_word", obs_data[i], lit[i]);
        check("t1_cycle", 64'(obs_cyc[i]), 64'(last_hs + 2 + i));
      end
    end

    // Frames of 1, 4 and exactly DEPTH words with random TVALID gaps.
    rand_route();
    obs_data.delete(); obs_cyc.delete();
    send_frame(1, 3);
    send_frame(4, 3);
    send_frame(DEPTH, 3);
    drain(500);
    check("t2_count", 64'(obs_data.size()), 64'd27);
    if (obs_data.size() == 27) begin
      check("t2_len1", obs_data[1], 64'd1);
      check("t2_len4", obs_data[4], 64'd4);
      check("t2_len16", obs_data[10], 64'd16);
    end
    check("t2_no_oversize", 64'(OVERSIZE), 64'd0);

    // Random backpressure during full-size and mixed packets.
    bp_rand = 1'b1;
    send_frame(DEPTH, 0);
    for (int f = 0; f < 4; f++) send_frame(int'($urandom_range(1, DEPTH)), 1);
    drain(2000);
    bp_rand = 1'b0;

    // Payload buffer full boundary and release timing.
    bp_force = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    send_frame(DEPTH, 0);
    @(negedge CLK);
    check("pay_full_tready", 64'(s_axis.TREADY), 64'd0);
    bp_force = 1'b0;
    @(posedge CLK);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("tready_before_read", 64'(s_axis.TREADY), 64'd0);
    @(negedge CLK);
    check("tready_after_read", 64'(s_axis.TREADY), 64'd1);
    @(posedge CLK); #1;
    drain(500);

    // Oversize: 20 words with TLAST only on the last one.
    obs_data.delete(); obs_cyc.delete();
    for (int i = 0; i < 20; i++) send_word(64'(i + 100), 1'(i == 19), 0);
    drain(500);
    check("t4_oversize", 64'(OVERSIZE), 64'd1);
    check("t4_count", 64'(obs_data.size()), 64'd24);
    if (obs_data.size() == 24) begin
      check("t4_len16", obs_data[1], 64'd16);
      check("t4_len4", obs_data[19], 64'd4);
    end
    send_frame(2, 0);
    drain(200);
    check("t4_sticky", 64'(OVERSIZE), 64'd1);

    // Length FIFO full while the output is held off.
    bp_force = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    obs_data.delete(); obs_cyc.delete();
    for (int f = 0; f < FL * 4; f++) begin
      send_frame(1, 0);
      if (f == 14) begin
        @(negedge CLK);
        check("tready_after_15", 64'(s_axis.TREADY), 64'd1);
        @(posedge CLK); #1;
      end
    end
    @(negedge CLK);
    check("len_full_tready", 64'(s_axis.TREADY), 64'd0);
    bp_force = 1'b0;
    @(posedge CLK); #1;
    drain(2000);
    check("t5_count", 64'(obs_data.size()), 64'd48);

    // Reset in the middle of a 10-word payload.
    obs_data.delete(); obs_cyc.delete();
    send_frame(10, 0);
    for (int w = 0; w < 200 && obs_data.size() < 5; w++) @(negedge CLK);
    check("t6_reached_pay", 64'(obs_data.size() >= 5), 64'd1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("t6_q_valid", 64'(Q_VALID), 64'd0);
    check("t6_tready", 64'(s_axis.TREADY), 64'd0);
    check("t6_oversize_cleared", 64'(OVERSIZE), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    obs_data.delete(); obs_cyc.delete();
    send_frame(3, 1);
    drain(200);
    check("t6_count", 64'(obs_data.size()), 64'd5);

    // Randomised traffic with random backpressure.
    rand_route();
    bp_rand = 1'b1;
    for (int f = 0; f < 25; f++) send_frame(int'($urandom_range(1, DEPTH)), 2);
    drain(5000);
    bp_rand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
